// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared types and constants for the APB master bridge.
//   - apb_mst_state_t : bridge FSM states
//   - APB_ADDR_W / APB_DATA_W : default APB address / data widths
//   - apb_cmd_t : one system-side command (direction, address, write data)
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_mst_state_t;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
//   Counts ACCESS-phase cycles and flags the cycle on which the wait limit is
//   reached.
//   i_clk     : clock
//   i_rst     : synchronous reset, active-high
//   i_clr     : clear the counter (transfer is entering SETUP)
//   i_en      : count this cycle (bridge is in ACCESS)
//   o_expired : current ACCESS cycle is the last one allowed
//               (never asserted when TIMEOUT_CYCLES = 0)
// -----------------------------------------------------------------------------
module apb_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [CW-1:0] r_cnt;

   // Saturating counter: it is never allowed to wrap back to a low value,
   // so a stuck transfer cannot sneak past the compare.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != {CW{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Counter holds the number of ACCESS cycles already completed, so
   // value TIMEOUT_CYCLES-1 marks the TIMEOUT_CYCLES-th ACCESS cycle.
   generate
      if (TIMEOUT_CYCLES == 0) begin : g_no_tmo
         assign o_expired = 1'b0;
      end else begin : g_tmo
         assign o_expired = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB3 requester. Accepts one command at a time on a valid/ready channel,
//   runs the SETUP/ACCESS handshake on the APB bus and returns the completion
//   on a valid/ready response channel. An ACCESS-phase timeout aborts
//   transfers whose slave never raises pready.
//   pclk / preset            : clock, synchronous active-high reset
//   cmd_valid/ready          : command handshake
//   cmd_write/addr/wdata     : command payload
//   rsp_valid/ready          : response handshake
//   rsp_rdata/err/timeout    : response payload
//   psel/penable/pwrite/
//   paddr/pwdata             : APB request outputs (all registered)
//   prdata/pready/pslverr    : APB completion inputs
// -----------------------------------------------------------------------------
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_mst_state_t    r_state;
   logic              r_cmd_ready;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_rsp_timeout;

   logic w_accept;
   logic w_aligned;
   logic w_start;
   logic w_in_access;
   logic w_expired;

   assign w_accept    = (r_state == IDLE) && cmd_valid && r_cmd_ready;
   assign w_aligned   = (cmd_addr[1:0] == 2'b00);
   assign w_start     = w_accept && w_aligned;
   assign w_in_access = (r_state == ACCESS);

   apb_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk     (pclk),
      .i_rst     (preset),
      .i_clr     (w_start),
      .i_en      (w_in_access),
      .o_expired (w_expired)
   );

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state       <= IDLE;
         r_cmd_ready   <= 1'b1;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  if (w_aligned) begin
                     // Bus fields are latched once here and held through
                     // ACCESS; read transfers drive zero write data.
                     r_state  <= SETUP;
                     r_psel   <= 1'b1;
                     r_pwrite <= cmd_write;
                     r_paddr  <= cmd_addr;
                     r_pwdata <= cmd_write ? cmd_wdata : '0;
                  end else begin
                     // Misaligned: answer with an error, never touch the bus.
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                  end
               end
            end
            SETUP: begin
               r_state   <= ACCESS;
               r_penable <= 1'b1;
            end
            ACCESS: begin
               // pready wins over the timeout on the final allowed cycle.
               if (pready) begin
                  r_state     <= RESP;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= pslverr;
                  r_rsp_rdata <= (!r_pwrite && !pslverr) ? prdata : '0;
               end else if (w_expired) begin
                  r_state       <= RESP;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_rdata   <= '0;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state       <= IDLE;
                  r_cmd_ready   <= 1'b1;
                  r_rsp_valid   <= 1'b0;
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b0;
                  r_rsp_timeout <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign paddr       = r_paddr;
   assign pwdata      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;
   import apb_pkg::*;

   localparam int TMO = 16;

   logic        pclk, preset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [31:0] paddr, pwdata, prdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   // ---------------- 32-word memory slave with programmable waits ----------
   logic [31:0] mem [32];
   int  acc_cnt = 0;
   int  wr_wait = 1;
   int  rd_wait = 2;
   bit  hang    = 0;

   always_comb begin
      pready = 1'b0;
      if (psel && penable && !hang)
         pready = (acc_cnt == (pwrite ? wr_wait : rd_wait));
   end
   assign pslverr = pready && (paddr >= 32'h80);
   assign prdata  = mem[paddr[6:2]];

   always @(posedge pclk) begin
      if (preset || !(psel && penable) || pready) acc_cnt <= 0;
      else                                         acc_cnt <= acc_cnt + 1;
      if (preset) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (psel && penable && pready && pwrite && paddr < 32'h80) begin
         mem[paddr[6:2]] <= pwdata;
      end
   end

   // ---------------- handshake monitors for the back-to-back scenario ------
   int          acc_times[$];
   logic [33:0] rsp_q[$];
   always @(posedge pclk) begin
      if (!preset && cmd_valid && cmd_ready) acc_times.push_back(cyc);
      if (!preset && rsp_valid && rsp_ready) rsp_q.push_back({rsp_err, rsp_timeout, rsp_rdata});
   end

   // ---------------- reference model (transaction level) -------------------
   logic [31:0] ref_mem [32];
   logic [31:0] e_rd;
   bit          e_err, e_to;
   int          e_acc, e_lat;

   // Expected outcome of one command: latency counted in clock edges from
   // the accepting edge to the edge that raises rsp_valid.
   function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] d);
      int need;
      e_rd = '0; e_err = 0; e_to = 0; e_acc = 0; e_lat = 1;
      if (a[1:0] != 2'b00) begin e_err = 1; return; end
      need = hang ? 1000 : ((w ? wr_wait : rd_wait) + 1);
      if (need > TMO) begin
         e_err = 1; e_to = 1; e_acc = TMO; e_lat = TMO + 2; return;
      end
      e_acc = need; e_lat = need + 2;
      if (a >= 32'h80) begin e_err = 1; return; end
      if (w) ref_mem[a[6:2]] = d;
      else   e_rd = ref_mem[a[6:2]];
   endfunction

   // ---------------- observations from one driven command ------------------
   int          o_lat, o_acc;
   bit          o_psel_seen, o_unstable, o_bus_at_rsp, o_cr_at_rsp, o_hold_bad, o_cleared, o_stuck;
   logic [31:0] o_rdata;
   bit          o_err, o_to;

   task automatic run_cmd(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold);
      int n;
      @(negedge pclk);
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
      o_stuck = (n >= 50);
      @(posedge pclk); #1;
      // Scramble the command bus: the DUT must be using its own copy now.
      cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      @(negedge pclk);
      o_lat = 1; o_acc = 0; o_psel_seen = 0; o_unstable = 0;
      while (!rsp_valid && o_lat < 100) begin
         if (psel) begin
            o_psel_seen = 1;
            if (paddr !== a || pwrite !== w || pwdata !== (w ? d : 32'h0)) o_unstable = 1;
         end
         if (psel && penable) o_acc++;
         @(negedge pclk); o_lat++;
      end
      o_rdata = rsp_rdata; o_err = rsp_err; o_to = rsp_timeout;
      o_bus_at_rsp = psel | penable; o_cr_at_rsp = cmd_ready;
      o_hold_bad = 0;
      if (hold > 0) begin
         // A competing command waits on cmd_valid while the response is held.
         cmd_valid = 1; cmd_write = 0; cmd_addr = {25'h0, 5'($urandom), 2'b00};
      end
      repeat (hold) begin
         @(negedge pclk);
         if (!rsp_valid || rsp_rdata !== o_rdata || rsp_err !== o_err ||
             rsp_timeout !== o_to || cmd_ready !== 1'b0) o_hold_bad = 1;
      end
      rsp_ready = 1;
      @(negedge pclk);
      rsp_ready = 0; cmd_valid = 0;
      o_cleared = (rsp_valid === 1'b0) && (rsp_err === 1'b0) && (rsp_timeout === 1'b0) &&
                  (rsp_rdata === 32'h0) && (cmd_ready === 1'b1);
   endtask

   // ---------------- scenarios ---------------------------------------------
   task automatic test_reset();
      preset = 1; cmd_valid = 0; rsp_ready = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      repeat (3) @(posedge pclk);
      @(negedge pclk); preset = 0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++;
         $display("FAIL reset_bus got %b exp 000", {psel, penable, pwrite}); end
      checks++; if ({paddr, pwdata} !== 64'h0) begin errors++;
         $display("FAIL reset_addr_data got %h exp 0", {paddr, pwdata}); end
      checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== 32'h0) begin errors++;
         $display("FAIL reset_rsp got %b/%h exp 000/0", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
      checks++; if (cmd_ready !== 1'b1) begin errors++;
         $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
   endtask

   task automatic test_write();
      wr_wait = 1; rd_wait = 2; hang = 0;
      model(1, 32'h10, 32'hDEADBEEF);
      run_cmd(1, 32'h10, 32'hDEADBEEF, 0);
      checks++; if (o_acc !== 2 || o_acc !== e_acc) begin errors++;
         $display("FAIL write_access_cycles got %0d exp %0d", o_acc, e_acc); end
      checks++; if (o_lat !== e_lat) begin errors++;
         $display("FAIL write_latency got %0d exp %0d", o_lat, e_lat); end
      checks++; if ({o_err, o_to} !== 2'b00 || o_rdata !== 32'h0) begin errors++;
         $display("FAIL write_rsp got %b/%h exp 00/0", {o_err, o_to}, o_rdata); end
      checks++; if (o_unstable !== 1'b0 || o_stuck !== 1'b0) begin errors++;
         $display("FAIL write_bus_stable got %b exp 0", o_unstable | o_stuck); end
      checks++; if (o_cleared !== 1'b1 || o_bus_at_rsp !== 1'b0) begin errors++;
         $display("FAIL write_rsp_clear got %b/%b exp 1/0", o_cleared, o_bus_at_rsp); end
   endtask

   task automatic test_read();
      model(0, 32'h10, 32'h0);
      run_cmd(0, 32'h10, 32'h12345678, 0);
      checks++; if (o_rdata !== 32'hDEADBEEF || o_rdata !== e_rd) begin errors++;
         $display("FAIL read_data got %h exp %h", o_rdata, e_rd); end
      checks++; if (o_acc !== 3 || o_lat !== e_lat) begin errors++;
         $display("FAIL read_timing got acc %0d lat %0d exp acc 3 lat %0d", o_acc, o_lat, e_lat); end
      checks++; if ({o_err, o_to, o_unstable} !== 3'b000) begin errors++;
         $display("FAIL read_flags got %b exp 000", {o_err, o_to, o_unstable}); end
   endtask

   task automatic test_misaligned();
      model(1, 32'h13, 32'hCAFEF00D);
      run_cmd(1, 32'h13, 32'hCAFEF00D, 0);
      checks++; if (o_lat !== 1 || o_psel_seen !== 1'b0) begin errors++;
         $display("FAIL misaligned_timing got lat %0d psel %b exp lat 1 psel 0", o_lat, o_psel_seen); end
      checks++; if ({o_err, o_to} !== 2'b10 || o_rdata !== 32'h0) begin errors++;
         $display("FAIL misaligned_rsp got %b/%h exp 10/0", {o_err, o_to}, o_rdata); end
   endtask

   task automatic test_timeout();
      hang = 1;
      model(0, 32'h20, 32'h0);
      run_cmd(0, 32'h20, 32'h0, 0);
      hang = 0;
      checks++; if (o_acc !== TMO || o_lat !== e_lat) begin errors++;
         $display("FAIL timeout_cycles got acc %0d lat %0d exp acc %0d lat %0d", o_acc, o_lat, TMO, e_lat); end
      checks++; if ({o_err, o_to, o_bus_at_rsp} !== 3'b110 || o_rdata !== 32'h0) begin errors++;
         $display("FAIL timeout_rsp got %b/%h exp 110/0", {o_err, o_to, o_bus_at_rsp}, o_rdata); end
      // pready on the last allowed ACCESS cycle is a normal completion.
      rd_wait = TMO - 1;
      model(0, 32'h10, 32'h0);
      run_cmd(0, 32'h10, 32'h0, 0);
      checks++; if ({o_err, o_to} !== 2'b00 || o_rdata !== e_rd || o_acc !== TMO) begin errors++;
         $display("FAIL timeout_edge_ok got %b/%h/%0d exp 00/%h/%0d", {o_err, o_to}, o_rdata, o_acc, e_rd, TMO); end
      rd_wait = TMO;
      model(0, 32'h10, 32'h0);
      run_cmd(0, 32'h10, 32'h0, 0);
      checks++; if ({o_err, o_to} !== {e_err, e_to} || o_acc !== e_acc) begin errors++;
         $display("FAIL timeout_edge_late got %b/%0d exp %b/%0d", {o_err, o_to}, o_acc, {e_err, e_to}, e_acc); end
      rd_wait = 2;
   endtask

   task automatic test_resp_hold();
      model(1, 32'h24, 32'hA5A55A5A);
      run_cmd(1, 32'h24, 32'hA5A55A5A, 5);
      checks++; if (o_hold_bad !== 1'b0 || o_cr_at_rsp !== 1'b0) begin errors++;
         $display("FAIL hold_stable got %b/%b exp 0/0", o_hold_bad, o_cr_at_rsp); end
      model(0, 32'h24, 32'h0);
      run_cmd(0, 32'h24, 32'h0, 3);
      checks++; if (o_rdata !== e_rd || o_hold_bad !== 1'b0) begin errors++;
         $display("FAIL hold_readback got %h/%b exp %h/0", o_rdata, o_hold_bad, e_rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int n;
      wr_wait = 0; rd_wait = 0;
      d = $urandom;
      acc_times.delete(); rsp_q.delete();
      @(negedge pclk);
      rsp_ready = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = d;
      n = 0;
      while (acc_times.size() < 1 && n < 40) begin @(negedge pclk); n++; end
      cmd_write = 0; cmd_addr = 32'h40; cmd_wdata = 32'h0;
      while (acc_times.size() < 2 && n < 40) begin @(negedge pclk); n++; end
      cmd_valid = 0;
      while (rsp_q.size() < 2 && n < 60) begin @(negedge pclk); n++; end
      rsp_ready = 0;
      void'(model(1, 32'h40, d));
      checks++; if (acc_times.size() != 2 || rsp_q.size() != 2) begin errors++;
         $display("FAIL b2b_handshakes got %0d/%0d exp 2/2", acc_times.size(), rsp_q.size()); end
      else begin
         checks++; if (acc_times[1] - acc_times[0] != 4) begin errors++;
            $display("FAIL b2b_spacing got %0d exp 4", acc_times[1] - acc_times[0]); end
         model(0, 32'h40, 32'h0);
         checks++; if (rsp_q[0] !== 34'h0 || rsp_q[1] !== {2'b00, e_rd}) begin errors++;
            $display("FAIL b2b_rsp got %h/%h exp 0/%h", rsp_q[0], rsp_q[1], e_rd); end
      end
      wr_wait = 1; rd_wait = 2;
   endtask

   task automatic test_random();
      apb_cmd_t c;
      int hold;
      for (int it = 0; it < 40; it++) begin
         wr_wait = $urandom_range(0, 3); rd_wait = $urandom_range(0, 3);
         c.write = 1'($urandom);
         c.wdata = $urandom;
         case ($urandom_range(0, 9))
            0:       c.addr = {25'h0, 5'($urandom), 2'b00} | 32'h1 << $urandom_range(0, 1);
            1:       c.addr = 32'h80 + {23'h0, 7'($urandom), 2'b00};
            default: c.addr = {25'h0, 3'($urandom), 2'b00, 2'b00};
         endcase
         hold = $urandom_range(0, 3);
         model(c.write, c.addr, c.wdata);
         run_cmd(c.write, c.addr, c.wdata, hold);
         checks++; if (o_rdata !== e_rd || o_err !== e_err || o_to !== e_to) begin errors++;
            $display("FAIL rand_rsp[%0d] a=%h w=%b got %h/%b%b exp %h/%b%b", it, c.addr, c.write,
                     o_rdata, o_err, o_to, e_rd, e_err, e_to); end
         checks++; if (o_acc !== e_acc || o_lat !== e_lat) begin errors++;
            $display("FAIL rand_timing[%0d] got acc %0d lat %0d exp acc %0d lat %0d", it,
                     o_acc, o_lat, e_acc, e_lat); end
         checks++; if (o_unstable || o_hold_bad || !o_cleared || o_psel_seen !== (e_acc != 0)) begin errors++;
            $display("FAIL rand_proto[%0d] got unst %b hold %b clr %b psel %b", it,
                     o_unstable, o_hold_bad, o_cleared, o_psel_seen); end
      end
      wr_wait = 1; rd_wait = 2;
   endtask

   task automatic test_reset_mid();
      int n;
      bit saw_rsp;
      hang = 1;
      @(negedge pclk);
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
      n = 0;
      while (!(psel && penable) && n < 20) begin @(negedge pclk); n++; end
      cmd_valid = 0;
      repeat (2) @(negedge pclk);
      checks++; if (penable !== 1'b1) begin errors++;
         $display("FAIL rst_mid_in_access got %b exp 1", penable); end
      preset = 1;
      @(negedge pclk);
      preset = 0; hang = 0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      checks++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin errors++;
         $display("FAIL rst_mid_state got %b exp 0001", {psel, penable, rsp_valid, cmd_ready}); end
      saw_rsp = 0;
      repeat (6) begin @(negedge pclk); if (rsp_valid || psel) saw_rsp = 1; end
      checks++; if (saw_rsp !== 1'b0) begin errors++;
         $display("FAIL rst_mid_no_rsp got %b exp 0", saw_rsp); end
   endtask

   initial begin
      preset = 1; cmd_valid = 0; rsp_ready = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      test_reset();
      test_write();
      test_read();
      test_misaligned();
      test_timeout();
      test_resp_hold();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit got expired exp finish");
      $fatal(1, "time limit");
   end

endmodule
